// File: rtl/l2_line_adapter.sv
// l2_line_adapter: converts one 256-bit L2 line request into a four-beat
// 64-bit memory burst, read or write. Beat k carries line bits
// [64k+63:64k], and beat 0 goes first.
module l2_line_adapter (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  address_i,
  input  logic         read_i,
  input  logic         write_i,
  input  logic [255:0] line_i,
  output logic [255:0] line_o,
  output logic         resp_o,
  output logic [31:0]  address_o,
  output logic         read_o,
  output logic         write_o,
  output logic [63:0]  burst_o,
  input  logic [63:0]  burst_i,
  input  logic         resp_i
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t       state_reg;
  logic [1:0]   cnt_reg;
  logic [31:0]  addr_q;
  logic [255:0] buf_q;

  // Beat offset into the line buffer: cnt * 64.
  logic [7:0]   beat_base;
  logic [63:0]  beat_word [4];

  assign beat_base = {cnt_reg, 6'b0};

  // Split the line buffer into its four beat words. This drives the write
  // data mux.
  for (genvar gi = 0; gi < 4; gi++) begin : g_beat
    assign beat_word[gi] = buf_q[64*gi +: 64];
  end

  // Burst sequencer. It latches the request on acceptance, counts beats on
  // resp_i, and flags completion for one cycle in DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      cnt_reg   <= 2'd0;
      addr_q    <= 32'd0;
      buf_q     <= 256'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          // A writeback takes priority over a read. The L2 expects its
          // dirty victim to leave before the refill arrives.
          if (write_i) begin
            state_reg <= WRITE;
            addr_q    <= address_i & 32'hFFFF_FFE0;
            buf_q     <= line_i;
            cnt_reg   <= 2'd0;
          end else if (read_i) begin
            state_reg <= READ;
            addr_q    <= address_i & 32'hFFFF_FFE0;
            cnt_reg   <= 2'd0;
          end
        end
        READ: begin
          if (resp_i) begin
            buf_q[beat_base +: 64] <= burst_i;
            cnt_reg                <= cnt_reg + 2'd1;
            if (cnt_reg == 2'd3) begin
              state_reg <= DONE;
            end
          end
        end
        WRITE: begin
          if (resp_i) begin
            cnt_reg <= cnt_reg + 2'd1;
            if (cnt_reg == 2'd3) begin
              state_reg <= DONE;
            end
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Memory-side strobes and the completion pulse are decoded directly from
  // the state register, so they change on the same edge as the state.
  assign read_o    = (state_reg == READ);
  assign write_o   = (state_reg == WRITE);
  assign resp_o    = (state_reg == DONE);
  assign address_o = addr_q;
  assign line_o    = buf_q;
  assign burst_o   = write_o ? beat_word[cnt_reg] : 64'd0;

endmodule

// File: tb/tb_l2_line_adapter.sv
// Self-checking bench for l2_line_adapter.
// - The stimulus process pushes expected completions and write beats into
//   queues.
// - A monitor pops those entries and compares them against the DUT outputs.
// - A memory responder process serves bursts out of its own line store.
module tb_l2_line_adapter;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [31:0]  address_i = '0;
  logic         read_i = 1'b0;
  logic         write_i = 1'b0;
  logic [255:0] line_i = '0;
  logic [255:0] line_o;
  logic         resp_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic [63:0]  burst_o;
  logic [63:0]  burst_i = '0;
  logic         resp_i = 1'b0;

  l2_line_adapter dut (
    .clk       (clk),
    .rst       (rst),
    .address_i (address_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .line_i    (line_i),
    .line_o    (line_o),
    .resp_o    (resp_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .burst_o   (burst_o),
    .burst_i   (burst_i),
    .resp_i    (resp_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           is_write;
    logic [31:0]  addr;
    logic [255:0] line;
  } exp_t;

  exp_t         exp_q[$];
  logic [63:0]  wbeat_q[$];
  bit           pat_q[$];
  logic [255:0] ref_mem [logic [26:0]];
  logic [255:0] bus_mem [logic [26:0]];

  int n_tests = 0;
  int n_fail  = 0;
  bit gap_en   = 0;
  bit stray_en = 0;
  int bcnt     = 0;
  bit prev_resp = 0;
  exp_t mon_e;

  task automatic check(string name, logic [255:0] act, logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Default content of a line that nobody has written yet. Both the model
  // and the responder use it, so they agree on it.
  function automatic logic [255:0] init_line(logic [26:0] k);
    logic [255:0] l;
    for (int b = 0; b < 4; b++) begin
      l[64*b +: 64] = {b[4:0], k, 32'hC0DE_0000 + b};
    end
    return l;
  endfunction

  function automatic logic [255:0] ref_line(logic [26:0] k);
    return ref_mem.exists(k) ? ref_mem[k] : init_line(k);
  endfunction

  function automatic logic [255:0] bus_line(logic [26:0] k);
    return bus_mem.exists(k) ? bus_mem[k] : init_line(k);
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // Memory responder. It drives resp_i and burst_i just after each rising
  // edge. Read beats come from its own store; write beats go into it.
  always @(posedge clk) begin
    logic [255:0] ln;
    logic [26:0]  k;
    #1;
    if (!rst) begin
      resp_i = 1'b0;
      bcnt   = 0;
    end else if (read_o || write_o) begin
      if (pat_q.size() > 0) resp_i = pat_q.pop_front();
      else if (gap_en)      resp_i = ($urandom_range(0, 2) != 0);
      else                  resp_i = 1'b1;
      k  = address_o[31:5];
      ln = bus_line(k);
      if (read_o) begin
        burst_i = ln[64*bcnt +: 64];
      end else begin
        burst_i = {$urandom, $urandom};
        if (resp_i) begin
          ln[64*bcnt +: 64] = burst_o;
          bus_mem[k] = ln;
        end
      end
      if (resp_i) bcnt = (bcnt + 1) % 4;
    end else begin
      resp_i  = stray_en ? 1'($urandom_range(0, 1)) : 1'b0;
      burst_i = {$urandom, $urandom};
      bcnt    = 0;
    end
  end

  // Monitor. It samples on the falling edge and compares the DUT against
  // the head of the scoreboard queues.
  always @(negedge clk) begin
    if (rst) begin
      check("addr_low_bits", {27'd0, address_o[4:0]}, 0);
      check("rd_wr_exclusive", {255'd0, read_o & write_o}, 0);
      if (!write_o) check("burst_o_idle_zero", {192'd0, burst_o}, 0);
      if (read_o || write_o) begin
        if (exp_q.size() == 0) check("busy_without_request", {255'd0, read_o | write_o}, 0);
        else check("busy_kind_write", {255'd0, write_o}, {255'd0, exp_q[0].is_write});
      end
      if (write_o && resp_i) begin
        if (wbeat_q.size() == 0) check("extra_write_beat", {255'd0, write_o}, 0);
        else check("write_beat", {192'd0, burst_o}, {192'd0, wbeat_q.pop_front()});
      end
      if (resp_o) begin
        check("resp_single_cycle", {255'd0, prev_resp}, 0);
        if (exp_q.size() == 0) begin
          check("resp_without_request", {255'd0, resp_o}, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("resp_address", {224'd0, address_o}, {224'd0, mon_e.addr});
          if (!mon_e.is_write) check("read_line", line_o, mon_e.line);
        end
      end
      prev_resp = resp_o;
    end else begin
      prev_resp = 1'b0;
    end
  end

  task automatic idle(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Issue one L2 request and hold it until resp_o shows. A non-zero exp_lat
  // is the required number of cycles from issue to resp_o.
  task automatic txn(bit wr, bit rd, logic [31:0] addr, logic [255:0] line, int exp_lat);
    exp_t e;
    int cyc;
    address_i = addr;
    line_i    = line;
    write_i   = wr;
    read_i    = rd;
    e.is_write = wr;
    e.addr     = {addr[31:5], 5'd0};
    if (wr) begin
      ref_mem[addr[31:5]] = line;
      e.line = line;
      for (int b = 0; b < 4; b++) wbeat_q.push_back(line[64*b +: 64]);
    end else begin
      e.line = ref_line(addr[31:5]);
    end
    exp_q.push_back(e);
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (!resp_o && cyc < 300);
    check("resp_seen", {255'd0, resp_o}, 1);
    read_i    = 1'b0;
    write_i   = 1'b0;
    address_i = $urandom;
    line_i    = rand256();
    if (exp_lat > 0) check("latency", cyc, exp_lat);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    exp_t         e;
    logic [255:0] d;
    logic [26:0]  k;
    int           kind;
    logic [31:0]  a;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_resp_o", {255'd0, resp_o}, 0);
    check("rst_read_o", {255'd0, read_o}, 0);
    check("rst_write_o", {255'd0, write_o}, 0);
    check("rst_address_o", {224'd0, address_o}, 0);
    check("rst_burst_o", {192'd0, burst_o}, 0);
    check("rst_line_o", line_o, 0);
    rst = 1'b1;
    idle(1);
    check("post_rst_line_o", line_o, 0);

    // Directed read with known beat data, back-to-back strobes.
    d = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
         64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    a = 32'h0000_1234;
    k = a[31:5];
    ref_mem[k] = d;
    bus_mem[k] = d;
    txn(0, 1, 32'h0000_1234, '0, 5);
    idle(1);

    // Directed write, then read the same line back.
    txn(1, 0, 32'h0000_2040, d, 5);
    idle(1);
    txn(0, 1, 32'h0000_2040, '0, 5);
    idle(1);

    // Gapped read: strobe pattern 1,0,0,1,1,0,1.
    pat_q = '{1, 0, 0, 1, 1, 0, 1};
    txn(0, 1, 32'h0000_3000, '0, 8);
    idle(1);

    // Both requests at once: the write wins. The read is then accepted in
    // the IDLE cycle right after DONE.
    txn(1, 1, 32'h0000_4000, rand256(), 5);
    txn(0, 1, 32'h0000_4000, '0, 6);
    idle(1);

    // Reset after the second beat of a read.
    a = 32'h0000_5000;
    k = a[31:5];
    d = rand256();
    ref_mem[k] = d;
    bus_mem[k] = d;
    pat_q = '{1, 1, 0, 0, 0, 0, 0, 0};
    idle(1);
    address_i = a;
    read_i    = 1'b1;
    e.is_write = 0;
    e.addr     = a;
    e.line     = d;
    exp_q.push_back(e);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    #2;
    rst    = 1'b0;
    read_i = 1'b0;
    exp_q.delete();
    #1;
    check("async_rst_resp_o", {255'd0, resp_o}, 0);
    check("async_rst_read_o", {255'd0, read_o}, 0);
    check("async_rst_write_o", {255'd0, write_o}, 0);
    check("async_rst_address_o", {224'd0, address_o}, 0);
    check("async_rst_burst_o", {192'd0, burst_o}, 0);
    check("async_rst_line_o", line_o, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    pat_q.delete();
    idle(1);
    check("post_rst_idle", {253'd0, read_o, write_o, resp_o}, 0);
    d = rand256();
    ref_mem[k] = d;
    bus_mem[k] = d;
    txn(0, 1, a, '0, 5);
    idle(1);

    // Stray strobes while idle must not advance the beat count.
    stray_en = 1;
    idle(6);
    stray_en = 0;
    txn(0, 1, 32'h0000_6000, '0, 5);
    idle(1);

    // Randomized traffic over a small set of lines.
    for (int i = 0; i < 40; i++) begin
      kind     = $urandom_range(0, 2);
      gap_en   = 1'($urandom_range(0, 1));
      stray_en = 1'($urandom_range(0, 1));
      a = 32'h0001_0000 | (32'($urandom_range(0, 7)) << 5) | 32'($urandom_range(0, 31));
      if (kind == 0)      txn(0, 1, a, rand256(), 0);
      else if (kind == 1) txn(1, 0, a, rand256(), 0);
      else                txn(1, 1, a, rand256(), 0);
      idle($urandom_range(0, 2));
    end
    gap_en   = 0;
    stray_en = 0;
    idle(3);
    check("scoreboard_drained", exp_q.size(), 0);
    check("write_beats_drained", wbeat_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
